// File: rtl/uart_cmd_decoder_if.sv
// RX byte stream in, decoded command pulses out, between uart_rx and the watch controller.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_err;
  logic       busy;

  // Drives the byte stream and observes the decoded commands.
  modport master (
    output rx_data,
    output rx_done,
    input  cmd_valid,
    input  cmd_code,
    input  cmd_err,
    input  busy
  );

  // Implemented by the decoder.
  modport slave (
    input  rx_data,
    input  rx_done,
    output cmd_valid,
    output cmd_code,
    output cmd_err,
    output busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Line assembler and command matcher for ASCII commands received over UART.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line buffer empty; terminators and backspaces are ignored
// COLLECT | at least one character buffered; waiting for CR/LF
// DECODE  | one cycle: match the buffered line and register the result
module uart_cmd_decoder #(
  parameter int MAXLEN = 8
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_decoder_if.slave bus
);

  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DECODE} state_t;

  state_t        state_q, state_nxt;
  logic [7:0]    line_q [MAXLEN];
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          is_term, is_bs, is_store;
  logic [7:0]    folded;
  logic [2:0]    code_match;

  logic          cmd_valid_q, cmd_err_q, busy_q;
  logic [2:0]    cmd_code_q;
  logic          cmd_valid_nxt, cmd_err_nxt;
  logic [2:0]    cmd_code_nxt;

  // Classify the incoming byte and fold upper case to lower case.
  always_comb begin
    is_term  = bus.rx_done && (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A);
    is_bs    = bus.rx_done && (bus.rx_data == 8'h08);
    is_store = bus.rx_done && !is_term && !is_bs;
    folded   = bus.rx_data;
    if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h5A) folded = bus.rx_data + 8'h20;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic; a backspace that empties the line returns to IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (is_store) state_nxt = COLLECT;
      COLLECT: begin
        if (is_term)                              state_nxt = DECODE;
        else if (is_bs && count_q == CW'(1))      state_nxt = IDLE;
      end
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Character count and sticky overflow flag; bytes arriving during DECODE are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_store) count_q <= CW'(1);
        end
        COLLECT: begin
          if (is_store) begin
            if (count_q == CW'(MAXLEN)) ovf_q   <= 1'b1;
            else                        count_q <= count_q + CW'(1);
          end else if (is_bs && count_q != '0) begin
            count_q <= count_q - CW'(1);
          end
        end
        DECODE: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
        default: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage; contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (is_store && state_q != DECODE) begin
      for (int i = 0; i < MAXLEN; i++) begin
        if (count_q == CW'(i)) line_q[i] <= folded;
      end
    end
  end

  // Exact match of the buffered line against the command set.
  always_comb begin
    code_match = 3'd0;
    if (count_q == CW'(3) && line_q[0] == "r" && line_q[1] == "u" && line_q[2] == "n")
      code_match = 3'd1;
    else if (count_q == CW'(4) && line_q[0] == "s" && line_q[1] == "t" &&
             line_q[2] == "o" && line_q[3] == "p")
      code_match = 3'd2;
    else if (count_q == CW'(5) && line_q[0] == "c" && line_q[1] == "l" &&
             line_q[2] == "e" && line_q[3] == "a" && line_q[4] == "r")
      code_match = 3'd3;
    else if (count_q == CW'(4) && line_q[0] == "m" && line_q[1] == "o" &&
             line_q[2] == "d" && line_q[3] == "e")
      code_match = 3'd4;
  end

  // Output decode: pulses only out of DECODE, code held otherwise.
  always_comb begin
    cmd_valid_nxt = 1'b0;
    cmd_err_nxt   = 1'b0;
    cmd_code_nxt  = cmd_code_q;
    if (state_q == DECODE) begin
      if (!ovf_q && code_match != 3'd0) begin
        cmd_valid_nxt = 1'b1;
        cmd_code_nxt  = code_match;
      end else begin
        cmd_err_nxt  = 1'b1;
        cmd_code_nxt = 3'd0;
      end
    end
  end

  // Output registers; busy follows the next state so it drops with the result pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_code_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_nxt;
      cmd_err_q   <= cmd_err_nxt;
      cmd_code_q  <= cmd_code_nxt;
      busy_q      <= (state_nxt != IDLE);
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with hand-computed expectations.
module tb_uart_cmd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   v0, e0;

  uart_cmd_decoder_if u_if ();

  uart_cmd_decoder #(.MAXLEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (u_if.cmd_valid) n_valid++;
    if (u_if.cmd_err)   n_err++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    u_if.rx_data = b;
    u_if.rx_done = 1'b1;
    @(negedge clk);
    u_if.rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Consecutive-cycle strobes; returns mid-cycle after the last strobe was sampled.
  task automatic send_burst(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      u_if.rx_data = s[i];
      u_if.rx_done = 1'b1;
    end
    @(negedge clk);
    u_if.rx_done = 1'b0;
  endtask

  // Called mid-cycle N+1 after the terminator strobe at cycle N.
  task automatic expect_pulse(input string tag, input int ev, input int ee, input int ec);
    chk({tag, " pre"}, {u_if.cmd_valid, u_if.cmd_err}, 0);
    @(negedge clk);
    chk({tag, " valid"}, u_if.cmd_valid, ev);
    chk({tag, " err"}, u_if.cmd_err, ee);
    chk({tag, " code"}, u_if.cmd_code, ec);
    @(negedge clk);
    chk({tag, " post"}, {u_if.cmd_valid, u_if.cmd_err}, 0);
    chk({tag, " held"}, u_if.cmd_code, ec);
    chk({tag, " busy"}, u_if.busy, 0);
  endtask

  initial begin
    u_if.rx_data = 8'h00;
    u_if.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", u_if.cmd_valid, 0);
    chk("rst err", u_if.cmd_err, 0);
    chk("rst code", u_if.cmd_code, 0);
    chk("rst busy", u_if.busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Slow "run" with CR.
    send_byte("r", 100);
    chk("busy after r", u_if.busy, 1);
    send_byte("u", 100);
    send_byte("n", 100);
    send_byte(8'h0D, 0);
    expect_pulse("run", 1, 0, 1);

    // Upper case, then a trailing LF that must not pulse.
    send_burst("STOP\r");
    expect_pulse("stop", 1, 0, 2);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h0A, 3);
    chk("lf no valid", n_valid - v0, 0);
    chk("lf no err", n_err - e0, 0);
    chk("lf code held", u_if.cmd_code, 2);

    send_burst("Clear\n");
    expect_pulse("clear", 1, 0, 3);

    // Backspace editing.
    send_burst("mox");
    send_byte(8'h08, 0);
    send_burst("de\r");
    expect_pulse("mode", 1, 0, 4);

    v0 = n_valid; e0 = n_err;
    send_byte("x", 0);
    send_byte(8'h08, 1);
    chk("bs empty busy", u_if.busy, 0);
    send_byte(8'h0D, 3);
    chk("bs empty valid", n_valid - v0, 0);
    chk("bs empty err", n_err - e0, 0);
    chk("bs empty code", u_if.cmd_code, 4);

    // Length mismatches.
    send_burst("runx\r");
    expect_pulse("runx", 0, 1, 0);
    send_burst("ru\r");
    expect_pulse("ru", 0, 1, 0);

    // Overflow, then a clean line.
    send_burst("abcdefghij\r");
    expect_pulse("ovf", 0, 1, 0);
    send_burst("run\r");
    expect_pulse("after ovf", 1, 0, 1);

    // Reset mid-line discards "sto".
    send_burst("sto");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst code", u_if.cmd_code, 0);
    chk("midrst busy", u_if.busy, 0);
    @(negedge clk);
    chk("midrst valid", u_if.cmd_valid, 0);
    chk("midrst err", u_if.cmd_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_burst("p\r");
    expect_pulse("p after rst", 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
